// File: rtl/rv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package rv_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    localparam int unsigned MDU_STEPS = 32;

endpackage

// File: rtl/rv_mdu_step.sv
// One radix-2 iteration on the {hi,lo} working pair: shift-add for multiply,
// restoring shift-subtract for divide, both through a single adder.
module rv_mdu_step #(
    parameter int unsigned BW = 32
) (
    input  logic          div_i,
    input  logic [BW-1:0] hi_i,
    input  logic [BW-1:0] lo_i,
    input  logic [BW-1:0] b_i,
    output logic [BW-1:0] hi_o,
    output logic [BW-1:0] lo_o
);

    logic [BW+1:0] opa;
    logic [BW+1:0] opb;
    logic [BW+1:0] sum;
    logic [BW-1:0] rem_sh;

    always_comb begin
        rem_sh = {hi_i[BW-2:0], lo_i[BW-1]};
        if (div_i) begin
            // Subtract as add of the inverted divisor plus carry-in.
            opa = {1'b0, hi_i, lo_i[BW-1]};
            opb = ~{2'b00, b_i};
        end else begin
            opa = {2'b00, hi_i};
            opb = lo_i[0] ? {2'b00, b_i} : '0;
        end
        sum = opa + opb + {{(BW+1){1'b0}}, div_i};

        if (div_i) begin
            if (sum[BW+1]) begin
                hi_o = rem_sh;
                lo_o = {lo_i[BW-2:0], 1'b0};
            end else begin
                hi_o = sum[BW-1:0];
                lo_o = {lo_i[BW-2:0], 1'b1};
            end
        end else begin
            hi_o = sum[BW:1];
            lo_o = {sum[0], lo_i[BW-1:1]};
        end
    end

endmodule

// File: rtl/rv_ex_mdu.sv
// Iterative M-extension unit: sequencing, operand sign handling, divide
// corner cases and the registered result for the EX stage.
module rv_ex_mdu
    import rv_pkg::*;
#(
    parameter int unsigned BW_DATA = 32
) (
    input  logic               i_mdu_clk,
    input  logic               i_mdu_rstn,
    input  logic               i_mdu_start,
    input  mdu_op_e            i_mdu_op,
    input  logic               i_mdu_kill,
    input  logic [BW_DATA-1:0] i_mdu_a,
    input  logic [BW_DATA-1:0] i_mdu_b,
    output logic               o_mdu_stall,
    output logic               o_mdu_done,
    output logic [BW_DATA-1:0] o_mdu_res
);

    localparam logic [5:0]         LAST_STEP = 6'(MDU_STEPS - 1);
    localparam logic [BW_DATA-1:0] INT_MIN   = {1'b1, {(BW_DATA-1){1'b0}}};

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [BW_DATA-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
    logic [5:0]         cnt_q, cnt_d;

    logic               accept, a_signed, b_signed, neg_a, neg_b, div0, ovf, neg;
    logic [BW_DATA-1:0] a_mag, b_mag, fast_res, step_hi, step_lo, quo, rem, fin_res;
    logic [2*BW_DATA-1:0] prod;

    rv_mdu_step #(.BW(BW_DATA)) u_step (
        .div_i (op_q[2]),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .b_i   (b_q),
        .hi_o  (step_hi),
        .lo_o  (step_lo)
    );

    always_comb begin
        accept   = (state_q == MDU_IDLE) && i_mdu_start && !i_mdu_kill;
        a_signed = (i_mdu_op == MDU_MULH) || (i_mdu_op == MDU_MULHSU) ||
                   (i_mdu_op == MDU_DIV)  || (i_mdu_op == MDU_REM);
        b_signed = (i_mdu_op == MDU_MULH) || (i_mdu_op == MDU_DIV) || (i_mdu_op == MDU_REM);
        neg_a    = a_signed && i_mdu_a[BW_DATA-1];
        neg_b    = b_signed && i_mdu_b[BW_DATA-1];
        a_mag    = neg_a ? -i_mdu_a : i_mdu_a;
        b_mag    = neg_b ? -i_mdu_b : i_mdu_b;
        div0     = i_mdu_op[2] && (i_mdu_b == '0);
        ovf      = ((i_mdu_op == MDU_DIV) || (i_mdu_op == MDU_REM)) &&
                   (i_mdu_a == INT_MIN) && (i_mdu_b == '1);
        if (div0) fast_res = i_mdu_op[1] ? i_mdu_a : '1;
        else      fast_res = i_mdu_op[1] ? '0 : INT_MIN;

        // Magnitudes were iterated; restore signs on the final step's outputs.
        neg     = sa_q ^ sb_q;
        prod    = {step_hi, step_lo};
        prod    = neg ? -prod : prod;
        quo     = neg ? -step_lo : step_lo;
        rem     = sa_q ? -step_hi : step_hi;
        if (op_q[2])              fin_res = op_q[1] ? rem : quo;
        else if (op_q == MDU_MUL) fin_res = prod[BW_DATA-1:0];
        else                      fin_res = prod[2*BW_DATA-1:BW_DATA];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            MDU_IDLE: if (accept) begin
                op_d  = i_mdu_op;
                sa_d  = neg_a;
                sb_d  = neg_b;
                hi_d  = '0;
                lo_d  = a_mag;
                b_d   = b_mag;
                cnt_d = '0;
                if (div0 || ovf) begin
                    state_d = MDU_DONE;
                    res_d   = fast_res;
                end else begin
                    state_d = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = MDU_DONE;
                    res_d   = fin_res;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
        if (i_mdu_kill) begin
            state_d = MDU_IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge i_mdu_clk or negedge i_mdu_rstn) begin
        if (!i_mdu_rstn) begin
            state_q <= MDU_IDLE;
            op_q    <= MDU_MUL;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Gated by reset so a held start cannot raise stall while in reset.
    assign o_mdu_stall = i_mdu_rstn && (accept || (state_q == MDU_BUSY));
    assign o_mdu_done  = (state_q == MDU_DONE);
    assign o_mdu_res   = res_q;

endmodule

// File: tb/tb_rv_ex_mdu.sv
// Directed bench for rv_ex_mdu: results, latency, divide corner cases, kill and reset.
module tb_rv_ex_mdu;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    mdu_op_e     op;
    logic        kill;
    logic [31:0] a, b;
    logic        stall, done;
    logic [31:0] res;

    int errors = 0;
    int checks = 0;

    rv_ex_mdu #(.BW_DATA(32)) dut (
        .i_mdu_clk   (clk),
        .i_mdu_rstn  (rstn),
        .i_mdu_start (start),
        .i_mdu_op    (op),
        .i_mdu_kill  (kill),
        .i_mdu_a     (a),
        .i_mdu_b     (b),
        .o_mdu_stall (stall),
        .o_mdu_done  (done),
        .o_mdu_res   (res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered and left at negedge+1; starts the op immediately in that cycle.
    task automatic run_op(input string tag, input mdu_op_e o, input logic [31:0] ai,
                          input logic [31:0] bi, input logic [31:0] exp,
                          input int exp_stall, input int exp_done);
        int cyc = 0;
        int stall_cnt = 0;
        int done_cyc = 0;
        start = 1'b1; op = o; a = ai; b = bi;
        #1;
        while (done_cyc == 0 && cyc < 100) begin
            cyc++;
            if (done) done_cyc = cyc;
            else begin
                if (stall) stall_cnt++;
                @(negedge clk); #1;
            end
        end
        check({tag, " stall_in_done"}, 32'(stall), 32'd0);
        start = 1'b0;
        check({tag, " res"}, res, exp);
        check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
        @(negedge clk); #1;
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " res_held"}, res, exp);
        check({tag, " idle_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        int ndone;
        rstn = 1'b0; start = 1'b0; op = MDU_MUL; kill = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset res", res, 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        @(negedge clk); rstn = 1'b1; #1;

        run_op("MUL 7*-3",  MDU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 34);
        run_op("MULH",      MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 34);
        run_op("MULHU",     MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 34);
        run_op("MULHSU",    MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 34);
        run_op("DIV -7/2",  MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 34);
        run_op("REM -7/2",  MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 34);
        run_op("DIVU 100/7", MDU_DIVU,  32'd100,      32'd7,        32'd14,       33, 34);
        run_op("REMU 100/7", MDU_REMU,  32'd100,      32'd7,        32'd2,        33, 34);

        // Kill during BUSY cycle 10: accept is cycle 1, so BUSY cycle 10 is cycle 11.
        start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd7;
        repeat (10) @(negedge clk);
        #1;
        check("kill busy stall", 32'(stall), 32'd1);
        kill = 1'b1; start = 1'b0;
        @(negedge clk); #1;
        kill = 1'b0;
        check("kill next stall", 32'(stall), 32'd0);
        check("kill next done", 32'(done), 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (done) ndone++;
        end
        check("kill no done", 32'(ndone), 32'd0);
        check("kill res held", res, 32'd2);
        run_op("DIVU 9/3", MDU_DIVU, 32'd9, 32'd3, 32'd3, 33, 34);

        run_op("DIV 5/0",  MDU_DIV, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 2);
        run_op("REM 5/0",  MDU_REM, 32'd5,        32'd0,        32'd5,        1, 2);
        run_op("DIV ovf",  MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 2);
        run_op("REM ovf",  MDU_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 2);
        run_op("DIVU 7/7", MDU_DIVU, 32'd7, 32'd7, 32'd1, 33, 34);

        // Asynchronous reset mid-BUSY with start still held high.
        start = 1'b1; op = MDU_MUL; a = 32'h12345678; b = 32'd9;
        repeat (6) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst async res", res, 32'd0);
        check("rst async done", 32'(done), 32'd0);
        check("rst async stall", 32'(stall), 32'd0);
        start = 1'b0;
        @(negedge clk); rstn = 1'b1; #1;
        @(negedge clk); #1;
        check("rst release idle stall", 32'(stall), 32'd0);
        check("rst release done", 32'(done), 32'd0);
        run_op("MUL 3*4", MDU_MUL, 32'd3, 32'd4, 32'd12, 33, 34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
